// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the E-stage branch resolver: data width, branch
// condition encodings and redirect FSM states.
package branch_resolve_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [0:0] state_t;
    localparam state_t S_IDLE     = 1'b0;
    localparam state_t S_REDIRECT = 1'b1;

endpackage

// File: rtl/branch_resolve_if.sv
// E-stage operand bundle in, fetch redirect and performance counters out.
interface branch_resolve_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    import branch_resolve_pkg::*;

    logic                 ValidE;
    logic                 StallE;
    logic                 BranchE;
    logic                 JumpE;
    logic                 JALROn;
    logic [2:0]           Funct3E;
    logic [XLEN-1:0]      RD1E;
    logic [XLEN-1:0]      RD2E;
    logic [XLEN-1:0]      PCE;
    logic [XLEN-1:0]      ImmExtE;
    logic                 PCSrc;
    logic [XLEN-1:0]      PCTargetE;
    logic                 FlushD;
    logic                 FlushE;
    logic                 MisalignE;
    logic [CNT_WIDTH-1:0] BranchCount;
    logic [CNT_WIDTH-1:0] TakenCount;

    modport master (
        output ValidE, StallE, BranchE, JumpE, JALROn, Funct3E, RD1E, RD2E, PCE, ImmExtE,
        input  PCSrc, PCTargetE, FlushD, FlushE, MisalignE, BranchCount, TakenCount
    );

    modport slave (
        input  ValidE, StallE, BranchE, JumpE, JALROn, Funct3E, RD1E, RD2E, PCE, ImmExtE,
        output PCSrc, PCTargetE, FlushD, FlushE, MisalignE, BranchCount, TakenCount
    );

endinterface

// File: rtl/branch_resolve_cmp.sv
// Combinational branch condition evaluator over the forwarded operands.
module branch_cmp
    import branch_resolve_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_cond
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_rs1 == i_rs2);
    assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
    assign w_ltu = (i_rs1 < i_rs2);

    always_comb begin
        o_cond = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_cond = w_eq;
            F3_BNE:  o_cond = !w_eq;
            F3_BLT:  o_cond = w_lt;
            F3_BGE:  o_cond = !w_lt;
            F3_BLTU: o_cond = w_ltu;
            F3_BGEU: o_cond = !w_ltu;
            default: o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves E-stage branches/jumps into a fetch redirect, wrong-path flushes,
// a misaligned-target pulse and branch performance counters.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter bit          REG_REDIRECT = 1'b0,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input logic             clk,
    input logic             rst,
    branch_resolve_if.slave bus
);

    logic            w_cond;
    logic            w_in_redirect;
    logic            w_resolve;
    logic            w_taken;
    logic            w_misalign;
    logic            w_redirect_now;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_target;

    logic [CNT_WIDTH-1:0] r_branch_cnt;
    logic [CNT_WIDTH-1:0] r_taken_cnt;

    branch_cmp u_cmp (
        .i_funct3 (bus.Funct3E),
        .i_rs1    (bus.RD1E),
        .i_rs2    (bus.RD2E),
        .o_cond   (w_cond)
    );

    always_comb begin
        w_sum    = bus.JALROn ? (bus.RD1E + bus.ImmExtE) : (bus.PCE + bus.ImmExtE);
        w_target = bus.JALROn ? (w_sum & ~32'h1) : w_sum;
    end

    // The instruction seen during a registered redirect is wrong-path and never resolves.
    assign w_resolve      = bus.ValidE && !bus.StallE && (bus.BranchE || bus.JumpE) &&
                            !w_in_redirect;
    assign w_taken        = w_resolve && (bus.JumpE || (bus.BranchE && w_cond));
    assign w_misalign     = w_taken && w_target[1];
    assign w_redirect_now = w_taken && !w_misalign;

    assign bus.MisalignE  = w_misalign;

    generate
        if (REG_REDIRECT) begin : g_reg
            state_t          r_state;
            logic [XLEN-1:0] r_target;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_state  <= S_IDLE;
                    r_target <= '0;
                end else begin
                    // REDIRECT lasts one cycle; resolve is blocked there so this returns to IDLE.
                    r_state <= w_redirect_now ? S_REDIRECT : S_IDLE;
                    if (w_redirect_now) begin
                        r_target <= w_target;
                    end
                end
            end

            assign w_in_redirect = (r_state == S_REDIRECT);
            assign bus.PCSrc     = w_in_redirect;
            assign bus.FlushD    = w_in_redirect;
            assign bus.FlushE    = w_in_redirect;
            assign bus.PCTargetE = r_target;
        end else begin : g_comb
            assign w_in_redirect = 1'b0;
            assign bus.PCSrc     = w_redirect_now;
            assign bus.FlushD    = w_redirect_now;
            assign bus.FlushE    = w_redirect_now;
            assign bus.PCTargetE = w_target;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            if (w_resolve && bus.BranchE) begin
                r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
            end
            if (w_taken) begin
                r_taken_cnt <= r_taken_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.BranchCount = r_branch_cnt;
    assign bus.TakenCount  = r_taken_cnt;

endmodule
